// File: rtl/reg_serial_reader_if.sv
// Handshake and data bundle between a controlling FSM and reg_serial_reader.
// The master drives the word and the start request; the slave returns the serial stream and status.
interface reg_serial_reader_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] D;
  logic             start;
  logic             busy;
  logic             sout;
  logic             bit_valid;
  logic             done;

  modport master (
    output D,
    output start,
    input  busy,
    input  sout,
    input  bit_valid,
    input  done
  );

  modport slave (
    input  D,
    input  start,
    output busy,
    output sout,
    output bit_valid,
    output done
  );
endinterface

// File: rtl/reg_serial_reader.sv
// Serialises a captured parallel word MSB-first, holding each bit DIV clocks, with optional even parity.
// All outputs are flopped from the next-state values, so nothing combinational reaches them from start or D.
module reg_serial_reader #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIV    = 4,
  parameter int unsigned PARITY = 0
) (
  input  logic              CLK,
  input  logic              RST,
  reg_serial_reader_if.slave bus
);

  localparam int unsigned BCW  = $clog2(WIDTH + 2);
  localparam int unsigned DCW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned LAST = (PARITY != 0) ? WIDTH : WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DCW-1:0]   div_cnt_q, div_cnt_d;
  logic             busy_q, busy_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      busy_q    <= 1'b0;
      sout_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      busy_q    <= busy_d;
      sout_q    <= sout_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath update; DONE accepts a start just like IDLE.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          shreg_d   = bus.D;
          par_d     = ^bus.D;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (div_cnt_q == DCW'(DIV - 1)) begin
          div_cnt_d = '0;
          shreg_d   = shreg_q << 1;
          bit_cnt_d = BCW'(bit_cnt_q + 1'b1);
          if (bit_cnt_q == BCW'(LAST)) begin
            state_d = S_DONE;
          end
        end else begin
          div_cnt_d = DCW'(div_cnt_q + 1'b1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state; the parity flag replaces the MSB in the extra slot.
  always_comb begin
    busy_d = 1'b0;
    sout_d = 1'b0;
    done_d = 1'b0;
    if (state_d == S_SHIFT) begin
      busy_d = 1'b1;
      if ((PARITY != 0) && (bit_cnt_d == BCW'(WIDTH))) begin
        sout_d = par_d;
      end else begin
        sout_d = shreg_d[WIDTH-1];
      end
    end
    if (state_d == S_DONE) begin
      done_d = 1'b1;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.sout      = sout_q;
  assign bus.bit_valid = busy_q;
  assign bus.done      = done_q;

endmodule

// File: doc/reg_serial_reader.md
Name: reg_serial_reader

Overview:
- Reads a parallel word, typically the Q output of an enabled 8-bit register, and transmits it serially MSB-first.
- Each bit is held for a programmable number of clocks, with an optional even-parity bit appended.
- Sits on the read side of register storage, turning the stored value into a bit stream for a downstream serial consumer or display shifter.
- Uses a start/busy/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 8, number of data bits per frame (>=1).
- DIV, 4, clock cycles each serial bit is held (>=1).
- PARITY, 0, 1 appends one even-parity bit after the data bits; 0 sends data only.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  reset, synchronous, active-high.
- D  input  WIDTH  parallel word to read; sampled only when a start is accepted.
- start  input  1  request to read and transmit D; level-sampled each cycle.
- busy  output  1  high while a frame is being shifted out.
- sout  output  1  serial data, MSB first; 0 when not shifting.
- bit_valid  output  1  high while sout carries a frame bit (equals busy).
- done  output  1  one-cycle pulse after the last bit's final hold cycle.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (RST sampled on the rising edge of CLK). Reset state is IDLE with busy=0, sout=0, bit_valid=0, done=0, shift register=0, counters=0.
- Reset mid-frame aborts the frame immediately at that edge. No done pulse is generated.
- RST overrides start in the same cycle.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge: capture D into the shift register and compute even parity (XOR of D) into a parity flag.
  - bit counter <= 0, div counter <= 0, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT:
  - sout = current MSB of the shift register, or the parity flag during the parity slot.
  - busy=1, bit_valid=1.
  - div counter increments each cycle. When it reaches DIV-1, it wraps to 0, the shift register shifts left by one (zero fill), and the bit counter increments.
  - When the bit counter is at its last slot and the div counter is at DIV-1, go to DONE.
  - Last slot is WIDTH-1 when PARITY=0, or WIDTH when PARITY=1.
- DONE:
  - lasts exactly one cycle with done=1, busy=0, bit_valid=0, sout=0.
  - start=1 in DONE is accepted exactly as in IDLE: capture D and go to SHIFT. This gives back-to-back frames with a single-cycle gap.
  - Otherwise go to IDLE.
- start while in SHIFT is ignored, not queued. D changes during SHIFT have no effect.
- Latency: with start accepted at edge k, first bit on sout in cycle k+1. Frame occupies N*DIV cycles, where N = WIDTH + PARITY. done is high in cycle k+1+N*DIV.
- Outputs are registered or decoded directly from state/registers only. There is no combinational path from start or D to any output.
- Counter widths: bit counter is clog2(WIDTH+2) bits; div counter is max(1, clog2(DIV)) bits.
- DIV=1 is legal: one bit per cycle, and the div counter is always 0.
- WIDTH=1 is legal.

Test Plan:
- Reset then idle: hold RST=1 for 2 cycles, then start=0 for 10 cycles -> busy=0, sout=0, done=0 throughout.
- Basic frame: WIDTH=8, DIV=4, PARITY=0, D=8'hA5, start pulse at edge k -> sout=1,0,1,0,0,1,0,1, each held 4 cycles over cycles k+1..k+32 -> busy high exactly cycles k+1..k+32 -> done high only in cycle k+33.
- Parity frame: PARITY=1, DIV=4, D=8'h07 (three ones) -> sout=0,0,0,0,0,1,1,1 then parity bit 1 -> busy 36 cycles -> done in cycle k+37. Repeat with D=8'hA5 -> parity bit 0.
- Ignore start and D during SHIFT: D=8'hF0 started, then start=1 and D=8'h0F mid-frame -> transmitted bits remain 1,1,1,1,0,0,0,0 -> exactly one done pulse.
- Back-to-back: DIV=1, D=8'h81, start held high continuously -> frames repeat 1,0,0,0,0,0,0,1 -> done every 9th cycle with busy=0 only in the done cycle.
- Reset mid-frame: assert RST during bit 3 of a D=8'hFF frame -> next cycle busy=0, sout=0, no done pulse -> new start after RST low sends a full 8-bit frame.
